// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin memory arbiter with sub-word read-modify-write
module mem_port_arbiter #(
    parameter int READ_LAT   = 1,
    parameter bit FIRST_PORT = 1'b0
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_wr,
    input  logic [1:0]  p0_size,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_wr,
    input  logic [1:0]  p1_size,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic        p0_err,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [2:0]  state_out
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_ERR  = 3'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic        last_grant, port_q, wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, data_q, rdata_q;

    logic        req_any, win, sel_wr, rd_last, done_any, err_any;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata, load_val, merged;

    // Round-robin: a lone requester always wins, a tie goes to the port not granted last.
    always_comb begin
        req_any   = p0_req | p1_req;
        win       = (p0_req && p1_req) ? ~last_grant : p1_req;
        sel_wr    = win ? p1_wr    : p0_wr;
        sel_size  = win ? p1_size  : p0_size;
        sel_addr  = win ? p1_addr  : p0_addr;
        sel_wdata = win ? p1_wdata : p0_wdata;
    end

    assign rd_last = (state == S_RD) && (cnt == LAT);

    // Lane extraction for loads and lane merge for sub-word stores share the same lane select.
    always_comb begin
        load_val = mem_rdata;
        merged   = mem_rdata;
        case (size_q)
            2'b01: begin
                load_val = {24'h0, mem_rdata[{addr_q[1:0], 3'b000} +: 8]};
                merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            end
            2'b10: begin
                load_val = {16'h0, mem_rdata[{addr_q[1], 4'b0000} +: 16]};
                merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req_any) begin
                    if (sel_size == 2'b11 || (sel_size == 2'b10 && sel_addr[0])) begin
                        state_nx = S_ERR;
                    end else if (sel_wr && sel_size == 2'b00) begin
                        state_nx = S_WR;
                    end else begin
                        state_nx = S_RD;
                    end
                end
            end
            S_RD:    if (rd_last) state_nx = wr_q ? S_WR : S_IDLE;
            S_WR:    state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            last_grant <= ~FIRST_PORT;
            port_q     <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
        end else begin
            if (state == S_RD) begin
                cnt <= rd_last ? 3'd0 : cnt + 3'd1;
            end else begin
                cnt <= 3'd0;
            end
            if (state == S_IDLE && req_any) begin
                port_q     <= win;
                last_grant <= win;
                wr_q       <= sel_wr;
                size_q     <= sel_size;
                addr_q     <= sel_addr;
                data_q     <= sel_wdata;
            end
            // Sub-word stores keep the merged word for the following write cycle.
            if (rd_last) begin
                if (wr_q) begin
                    data_q <= merged;
                end else begin
                    rdata_q <= load_val;
                end
            end
        end
    end

    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        rdata     = rdata_q;
        done_any  = 1'b0;
        err_any   = 1'b0;
        case (state)
            S_IDLE: begin
                p0_gnt = req_any & ~win;
                p1_gnt = req_any & win;
            end
            S_RD: begin
                mem_addr = {addr_q[31:2], 2'b00};
                if (rd_last && !wr_q) begin
                    done_any = 1'b1;
                    rdata    = load_val;
                end
            end
            S_WR: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wr    = 1'b1;
                mem_wdata = data_q;
                done_any  = 1'b1;
            end
            S_ERR: begin
                done_any = 1'b1;
                err_any  = 1'b1;
            end
            default: ;
        endcase
        p0_done = done_any & ~port_q;
        p1_done = done_any & port_q;
        p0_err  = err_any & ~port_q;
        p1_err  = err_any & port_q;
    end

    assign busy      = (state != S_IDLE);
    assign state_out = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int RL  = 1;
    localparam int RL3 = 3;
    localparam bit FP  = 1'b0;

    logic Clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 Clk = ~Clk;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [1:0]  req = '0, wr = '0;
    logic [1:0]  size [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [1:0]  gnt, done, err;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, busy;
    logic [2:0]  state_out;

    logic [1:0]  q_req = '0;
    logic [1:0]  q_size [2];
    logic [31:0] q_addr [2];
    logic [31:0] q_wdata [2];
    logic [1:0]  q_gnt, q_done, q_err;
    logic [31:0] q_rdata, q_mem_addr, q_mem_wdata, q_mem_rdata;
    logic        q_mem_wr, q_busy;
    logic [2:0]  q_state;

    mem_port_arbiter #(.READ_LAT(RL), .FIRST_PORT(FP)) u_dut (
        .Clk(Clk), .reset_n(reset_n),
        .p0_req(req[0]), .p0_wr(wr[0]), .p0_size(size[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p1_req(req[1]), .p1_wr(wr[1]), .p1_size(size[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p0_gnt(gnt[0]), .p0_done(done[0]), .p0_err(err[0]),
        .p1_gnt(gnt[1]), .p1_done(done[1]), .p1_err(err[1]),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .state_out(state_out)
    );

    mem_port_arbiter #(.READ_LAT(RL3), .FIRST_PORT(1'b1)) u_dut3 (
        .Clk(Clk), .reset_n(reset_n),
        .p0_req(q_req[0]), .p0_wr(1'b0), .p0_size(q_size[0]), .p0_addr(q_addr[0]), .p0_wdata(q_wdata[0]),
        .p1_req(q_req[1]), .p1_wr(1'b0), .p1_size(q_size[1]), .p1_addr(q_addr[1]), .p1_wdata(q_wdata[1]),
        .p0_gnt(q_gnt[0]), .p0_done(q_done[0]), .p0_err(q_err[0]),
        .p1_gnt(q_gnt[1]), .p1_done(q_done[1]), .p1_err(q_err[1]),
        .rdata(q_rdata), .mem_addr(q_mem_addr), .mem_wr(q_mem_wr), .mem_wdata(q_mem_wdata),
        .mem_rdata(q_mem_rdata), .busy(q_busy), .state_out(q_state)
    );

    // Memories with a READ_LAT-deep read pipeline; aliased to 16 words on addr[5:2].
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    logic [31:0] bmem [16];
    logic [31:0] bmem3 [16];
    logic [31:0] pipe [RL];
    logic [31:0] pipe3 [RL3];

    always @(posedge Clk) begin
        pipe[0] <= bmem[mem_addr[5:2]];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        if (mem_wr) bmem[mem_addr[5:2]] <= mem_wdata;
        if (poke_en) bmem[poke_idx] <= poke_val;
    end
    assign mem_rdata = pipe[RL-1];

    always @(posedge Clk) begin
        pipe3[0] <= bmem3[q_mem_addr[5:2]];
        for (int i = 1; i < RL3; i++) pipe3[i] <= pipe3[i-1];
        if (q_mem_wr) bmem3[q_mem_addr[5:2]] <= q_mem_wdata;
        if (poke_en) bmem3[poke_idx] <= poke_val;
    end
    assign q_mem_rdata = pipe3[RL3-1];

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one planned transaction with its completion cycle.
    logic [31:0] mem_m [16];
    bit          m_active = 1'b0;
    bit          m_last = ~FP;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_done_q = '0;
    int          t_done_c;
    bit          t_port, t_err, t_wr, t_load;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [2:0]  t_fin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic plan(input bit w);
        logic [1:0]  sz;
        logic [31:0] a, wd, word;
        int          sh_b, sh_h;
        t_port = w;
        t_wr   = wr[w];
        sz     = size[w];
        a      = addr[w];
        wd     = wdata[w];
        t_addr = a;
        t_err  = (sz == 2'd3) || (sz == 2'd2 && a[0]);
        t_load = !t_wr && !t_err;
        word   = mem_m[a[5:2]];
        sh_b   = 8 * int'(a[1:0]);
        sh_h   = 16 * int'(a[1]);
        t_rdata = word;
        t_wdata = wd;
        if (sz == 2'd1) begin
            t_rdata = (word >> sh_b) & 32'hFF;
            t_wdata = (word & ~(32'hFF << sh_b)) | ((wd & 32'hFF) << sh_b);
        end else if (sz == 2'd2) begin
            t_rdata = (word >> sh_h) & 32'hFFFF;
            t_wdata = (word & ~(32'hFFFF << sh_h)) | ((wd & 32'hFFFF) << sh_h);
        end
        if (t_err) begin
            t_done_c = cyc + 1; t_fin = 3'd3;
        end else if (t_wr && sz == 2'd0) begin
            t_done_c = cyc + 1; t_fin = 3'd2;
        end else if (!t_wr) begin
            t_done_c = cyc + 1 + RL; t_fin = 3'd1;
        end else begin
            t_done_c = cyc + 2 + RL; t_fin = 3'd2;
        end
    endtask

    task automatic model_step();
        logic [1:0]  e_gnt, e_done, e_err;
        logic [31:0] e_addr;
        logic [2:0]  e_state;
        bit          e_wr, e_busy, addr_ok, was_active, w;
        if (poke_en) mem_m[poke_idx] = poke_val;
        if (!reset_n) begin
            m_active = 1'b0; m_last = ~FP; m_rdata = '0; m_done_q = '0;
            chk("rst_ctrl", 32'({gnt, done, err, mem_wr, busy, state_out}), 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_rdata", rdata, 32'h0);
            return;
        end
        e_gnt = '0; e_done = '0; e_err = '0; e_addr = '0; e_state = '0;
        e_wr = 1'b0; e_busy = 1'b0; addr_ok = 1'b1; w = 1'b0;
        was_active = m_active;
        if (m_active) begin
            e_busy  = 1'b1;
            e_addr  = {t_addr[31:2], 2'b00};
            addr_ok = !t_err;
            e_state = (cyc == t_done_c) ? t_fin : 3'd1;
            if (cyc == t_done_c) begin
                e_done[t_port] = 1'b1;
                e_err[t_port]  = t_err;
                e_wr = t_wr && !t_err;
                if (t_load) m_rdata = t_rdata;
            end
        end else if (req != 2'b00) begin
            w = (req == 2'b11) ? !m_last : req[1];
            e_gnt[w] = 1'b1;
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("state_out", 32'(state_out), 32'(e_state));
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        chk("rdata", rdata, m_rdata);
        if (addr_ok) chk("mem_addr", mem_addr, e_addr);
        if (e_wr) chk("mem_wdata", mem_wdata, t_wdata);
        if (was_active && cyc == t_done_c) begin
            m_active = 1'b0;
            if (e_wr) mem_m[t_addr[5:2]] = t_wdata;
        end else if (!was_active && req != 2'b00) begin
            m_last = w;
            plan(w);
            m_active = 1'b1;
        end
        m_done_q = e_done;
    endtask

    task automatic pos(); @(posedge Clk); #1; endtask
    task automatic neg(); @(negedge Clk); model_step(); endtask
    task automatic cyc1(); neg(); pos(); endtask

    task automatic poke(input logic [3:0] i, input logic [31:0] v);
        poke_en = 1'b1; poke_idx = i; poke_val = v;
        cyc1();
        poke_en = 1'b0;
    endtask

    task automatic txn(input bit p, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output bit e, output int nwr, output logic [31:0] wa, output logic [31:0] wdat);
        int g;
        g = -1; lat = -1; rd = '0; e = 1'b0; nwr = 0; wa = '0; wdat = '0;
        req[p] = 1'b1; wr[p] = w; size[p] = sz; addr[p] = a; wdata[p] = wd;
        for (int k = 0; k < 20; k++) begin
            neg();
            if (gnt[p] && g < 0) g = cyc;
            if (mem_wr) begin nwr++; wa = mem_addr; wdat = mem_wdata; end
            if (done[p]) begin
                lat = (g < 0) ? -2 : cyc - g;
                rd = rdata; e = err[p];
                pos();
                break;
            end
            pos();
        end
        req[p] = 1'b0;
        checks++;
        if (lat < 0) begin errors++; $display("FAIL txn_complete port %0d: got %0d want done", p, lat); end
    endtask

    task automatic q_run(input int raise1_at, output int g0, output int g1, output int d0,
                         output int d1, output logic [31:0] r0, output logic [31:0] r1);
        int base;
        g0 = -1; g1 = -1; d0 = -1; d1 = -1; r0 = '0; r1 = '0;
        base = cyc;
        q_size[0] = 2'd0; q_size[1] = 2'd0; q_addr[0] = 32'h10; q_addr[1] = 32'h20;
        q_wdata[0] = '0; q_wdata[1] = '0;
        q_req[0] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == raise1_at) q_req[1] = 1'b1;
            neg();
            if (q_gnt == 2'b11) chk("q_both_gnt", 32'(q_gnt), 32'h1);
            if (q_gnt[0] && g0 < 0) g0 = cyc - base;
            if (q_gnt[1] && g1 < 0) g1 = cyc - base;
            if (q_done[0]) begin d0 = cyc - base; r0 = q_rdata; end
            if (q_done[1]) begin d1 = cyc - base; r1 = q_rdata; end
            pos();
            q_req = q_req & ~q_done;
            if (d0 >= 0 && d1 >= 0) break;
        end
        q_req = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, nwr, g0, g1, d0, d1;
        bit e, both_g;
        logic [31:0] rd, wa, wdat, r0, r1;
        logic [1:0] d;
        int order[$];

        for (int i = 0; i < 2; i++) begin
            size[i] = '0; addr[i] = '0; wdata[i] = '0;
            q_size[i] = '0; q_addr[i] = '0; q_wdata[i] = '0;
        end
        pos();
        for (int i = 0; i < 16; i++) poke(4'(i), $urandom);
        reset_n = 1'b1;
        cyc1();

        // 1: word load
        poke(4'd4, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 2'd0, 32'h10, 32'h0, lat, rd, e, nwr, wa, wdat);
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_rdata", rd, 32'hDEADBEEF);
        chk("t1_nwr", 32'(nwr), 32'd0);

        // 2: simultaneous requests alternate from reset
        reset_n = 1'b0; cyc1(); reset_n = 1'b1; cyc1();
        both_g = 1'b0;
        wr = 2'b00; size[0] = 2'd0; size[1] = 2'd0; addr[0] = 32'h10; addr[1] = 32'h20;
        req = 2'b11;
        for (int k = 0; k < 100; k++) begin
            neg();
            if (gnt == 2'b11) both_g = 1'b1;
            if (gnt[0]) order.push_back(0);
            if (gnt[1]) order.push_back(1);
            d = done;
            pos();
            req = req & ~d;
            if (req == 2'b00) begin
                if (order.size() >= 6) break;
                req = 2'b11;
            end
        end
        req = 2'b00;
        chk("t2_grants", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6 && i < order.size(); i++) chk("t2_order", 32'(order[i]), 32'(i % 2));
        chk("t2_both_gnt", 32'(both_g), 32'd0);

        // 3: byte store read-modify-write
        poke(4'd8, 32'h11223344);
        txn(1'b1, 1'b1, 2'd1, 32'h21, 32'hFFFF_FFAB, lat, rd, e, nwr, wa, wdat);
        chk("t3_lat", 32'(lat), 32'd3);
        chk("t3_nwr", 32'(nwr), 32'd1);
        chk("t3_waddr", wa, 32'h20);
        chk("t3_wdata", wdat, 32'h1122AB44);
        chk("t3_err", 32'(e), 32'd0);

        // 4: halfword load, then misaligned halfword store
        poke(4'd8, 32'h11223344);
        txn(1'b1, 1'b0, 2'd2, 32'h22, 32'h0, lat, rd, e, nwr, wa, wdat);
        chk("t4_rdata", rd, 32'h00001122);
        chk("t4_lat", 32'(lat), 32'd2);
        txn(1'b1, 1'b1, 2'd2, 32'h23, 32'h5555, lat, rd, e, nwr, wa, wdat);
        chk("t4_err_lat", 32'(lat), 32'd1);
        chk("t4_err", 32'(e), 32'd1);
        chk("t4_err_nwr", 32'(nwr), 32'd0);
        txn(1'b0, 1'b0, 2'd1, 32'h23, 32'h0, lat, rd, e, nwr, wa, wdat);
        chk("t4_byte_rdata", rd, 32'h00000011);

        // 5: reset during the read phase of a byte store
        req[1] = 1'b1; wr[1] = 1'b1; size[1] = 2'd1; addr[1] = 32'h20; wdata[1] = 32'h77;
        neg();
        chk("t5_gnt", 32'(gnt[1]), 32'd1);
        pos();
        chk("t5_in_rd", 32'(state_out), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_state", 32'(state_out), 32'd0);
        chk("t5_mem_wr", 32'(mem_wr), 32'd0);
        req[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("t5_quiet", 32'({done, mem_wr}), 32'd0);
            pos();
        end
        reset_n = 1'b1;
        cyc1();
        txn(1'b0, 1'b0, 2'd0, 32'h20, 32'h0, lat, rd, e, nwr, wa, wdat);
        chk("t5_after_rdata", rd, 32'h11223344);
        chk("t5_after_lat", 32'(lat), 32'd2);

        // 6: READ_LAT=3 instance, FIRST_PORT=1
        q_run(0, g0, g1, d0, d1, r0, r1);
        chk("t6a_g1", 32'(g1), 32'd0);
        chk("t6a_d1", 32'(d1), 32'd4);
        chk("t6a_g0", 32'(g0), 32'd5);
        chk("t6a_d0", 32'(d0), 32'd9);
        chk("t6a_r1", r1, 32'h11223344);
        chk("t6a_r0", r0, 32'hDEADBEEF);
        q_run(1, g0, g1, d0, d1, r0, r1);
        chk("t6b_g0", 32'(g0), 32'd0);
        chk("t6b_d0", 32'(d0), 32'd4);
        chk("t6b_g1", 32'(g1), 32'd5);

        // Randomized traffic on both ports
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && m_done_q[p]) req[p] = 1'b0;
                if (!req[p] && $urandom_range(0, 2) == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    req[p]   = 1'b1;
                    wr[p]    = 1'($urandom_range(0, 1));
                    size[p]  = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                    addr[p]  = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
                    wdata[p] = $urandom;
                end
            end
            cyc1();
        end
        for (int k = 0; k < 40 && req != 2'b00; k++) begin
            req = req & ~m_done_q;
            cyc1();
        end
        req = 2'b00;
        cyc1();
        cyc1();
        for (int i = 0; i < 16; i++) chk("final_mem", bmem[i], mem_m[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
